// File: rtl/retire_trace_buffer_pkg.sv
// Shared types for the retire trace buffer.
// Optional timestamp field is controlled by TRACE_TIMESTAMP_EN.
package retire_trace_buffer_pkg;

   localparam int XLEN      = 32;
   localparam int TS_W      = 16;
   localparam int REG_IDX_W = 5;

   typedef logic [REG_IDX_W-1:0] reg_idx_t;

   typedef enum logic [1:0] {
      T_IDLE   = 2'd0,
      T_ARMED  = 2'd1,
      T_POST   = 2'd2,
      T_FROZEN = 2'd3
   } trace_state_e;

   typedef struct packed {
`ifdef TRACE_TIMESTAMP_EN
      logic [TS_W-1:0] ts;
`endif
      logic [XLEN-1:0] pc;
      logic [31:0]     instr;
      reg_idx_t        rd;
      logic            we;
      logic [XLEN-1:0] wdata;
   } trace_entry_t;

   function automatic int trace_cnt_w(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/retire_trace_buffer_if.sv
// Retire capture, control and drain signals of the trace buffer.
// master = core/consumer side, slave = trace buffer.
interface retire_trace_buffer_if #(
   parameter int DEPTH = 16
);
   import retire_trace_buffer_pkg::*;

   localparam int CNT_W = trace_cnt_w(DEPTH);

   logic             retire_valid;
   logic [XLEN-1:0]  retire_pc;
   logic [31:0]      retire_instr;
   reg_idx_t         retire_rd;
   logic             retire_we;
   logic [XLEN-1:0]  retire_wdata;
   logic             arm;
   logic             abort;
   logic             trig_en;
   logic [XLEN-1:0]  trig_pc;
   logic             rd_ready;
   logic             rd_valid;
   trace_entry_t     rd_entry;
   trace_state_e     state;
   logic [CNT_W-1:0] count;
   logic             wrapped;

   modport master (
      output retire_valid, retire_pc, retire_instr, retire_rd, retire_we, retire_wdata,
      output arm, abort, trig_en, trig_pc, rd_ready,
      input  rd_valid, rd_entry, state, count, wrapped
   );

   modport slave (
      input  retire_valid, retire_pc, retire_instr, retire_rd, retire_we, retire_wdata,
      input  arm, abort, trig_en, trig_pc, rd_ready,
      output rd_valid, rd_entry, state, count, wrapped
   );

endinterface

// File: rtl/retire_trace_buffer_trace_ram.sv
// Trace entry storage: one synchronous write port, one asynchronous read port.
// Contents are intentionally not reset; validity is tracked by the pointers/count.
module trace_ram
   import retire_trace_buffer_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  trace_entry_t  wdata,
   input  logic [AW-1:0] raddr,
   output trace_entry_t  rdata
);

   trace_entry_t mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/retire_trace_buffer.sv
// Retired-instruction trace buffer: arm, trigger on PC match, post-capture, freeze, drain.
// Define TRACE_TIMESTAMP_EN to stamp each entry with a free-running cycle counter.
//
// state    | meaning
// T_IDLE   | not capturing; waits for arm
// T_ARMED  | circular capture of every retire, watching for the trigger PC
// T_POST   | trigger seen; capturing the remaining post-trigger entries
// T_FROZEN | capture stopped; entries drained through rd_valid/rd_ready
module retire_trace_buffer
   import retire_trace_buffer_pkg::*;
#(
   parameter int DEPTH     = 16,
   parameter int POST_TRIG = 8
) (
   input logic                 clk,
   input logic                 rst_n,
   retire_trace_buffer_if.slave bus
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = trace_cnt_w(DEPTH);
   localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] POST_INIT = CNT_W'(POST_TRIG);
   localparam trace_state_e     TRIG_NEXT = (POST_TRIG == 0) ? T_FROZEN : T_POST;

   trace_state_e     state_q;
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] post_cnt;
   logic             wrapped_q;

   logic             capture;
   logic             trig_hit;
   logic             pop;
   trace_entry_t     wr_entry;
   trace_entry_t     rd_entry;

`ifdef TRACE_TIMESTAMP_EN
   logic [TS_W-1:0]  ts_q;

   always_ff @(posedge clk) begin
      if (!rst_n) ts_q <= '0;
      else        ts_q <= ts_q + 1'b1;
   end
`endif

   always_comb begin
      wr_entry       = '0;
      wr_entry.pc    = bus.retire_pc;
      wr_entry.instr = bus.retire_instr;
      wr_entry.rd    = bus.retire_rd;
      wr_entry.we    = bus.retire_we;
      wr_entry.wdata = bus.retire_wdata;
`ifdef TRACE_TIMESTAMP_EN
      wr_entry.ts    = ts_q;
`endif
   end

   assign capture  = bus.retire_valid && !bus.abort && rst_n &&
                     ((state_q == T_ARMED) || (state_q == T_POST));
   assign trig_hit = (state_q == T_ARMED) && bus.retire_valid && bus.trig_en &&
                     (bus.retire_pc == bus.trig_pc);
   assign pop      = (state_q == T_FROZEN) && (count_q != '0) && bus.rd_ready;

   trace_ram #(
      .DEPTH (DEPTH)
   ) u_trace_ram (
      .clk   (clk),
      .we    (capture),
      .waddr (wr_ptr),
      .wdata (wr_entry),
      .raddr (rd_ptr),
      .rdata (rd_entry)
   );

   always_ff @(posedge clk) begin
      if (!rst_n || bus.abort) begin
         state_q   <= T_IDLE;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count_q   <= '0;
         post_cnt  <= '0;
         wrapped_q <= 1'b0;
      end else begin
         unique case (state_q)
            T_IDLE: begin
               if (bus.arm) begin
                  state_q   <= T_ARMED;
                  wr_ptr    <= '0;
                  rd_ptr    <= '0;
                  count_q   <= '0;
                  post_cnt  <= '0;
                  wrapped_q <= 1'b0;
               end
            end
            T_ARMED, T_POST: begin
               if (bus.retire_valid) begin
                  wr_ptr <= wr_ptr + 1'b1;
                  // Full buffer: the new entry replaces the oldest, so the head moves too.
                  if (count_q == CNT_FULL) begin
                     rd_ptr    <= rd_ptr + 1'b1;
                     wrapped_q <= 1'b1;
                  end else begin
                     count_q <= count_q + 1'b1;
                  end
                  if (state_q == T_ARMED) begin
                     if (trig_hit) begin
                        post_cnt <= POST_INIT;
                        state_q  <= TRIG_NEXT;
                     end
                  end else begin
                     post_cnt <= post_cnt - 1'b1;
                     if (post_cnt == CNT_W'(1)) state_q <= T_FROZEN;
                  end
               end
            end
            T_FROZEN: begin
               if (pop) begin
                  rd_ptr  <= rd_ptr + 1'b1;
                  count_q <= count_q - 1'b1;
                  if (count_q == CNT_W'(1)) state_q <= T_IDLE;
               end
            end
            default: state_q <= T_IDLE;
         endcase
      end
   end

   assign bus.rd_valid = (state_q == T_FROZEN) && (count_q != '0);
   assign bus.rd_entry = rd_entry;
   assign bus.state    = state_q;
   assign bus.count    = count_q;
   assign bus.wrapped  = wrapped_q;

endmodule

// File: tb/tb_retire_trace_buffer.sv
// Scoreboard bench for retire_trace_buffer: two instances (POST_TRIG 8 and 0).
// Build with TRACE_TIMESTAMP_EN defined to exercise the timestamp field.
module tb_retire_trace_buffer;
   import retire_trace_buffer_pkg::*;

   localparam int DEPTH = 16;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [31:0] r_pc    = '0;
   logic [31:0] r_instr = '0;
   reg_idx_t    r_rd    = '0;
   logic        r_we    = 1'b0;
   logic [31:0] r_wdata = '0;
   logic        t_en    = 1'b0;
   logic [31:0] t_pc    = '0;
   logic        r_valid [2];
   logic        r_arm   [2];
   logic        r_abort [2];
   logic        r_ready [2];

   retire_trace_buffer_if #(.DEPTH(DEPTH)) if_a ();
   retire_trace_buffer_if #(.DEPTH(DEPTH)) if_b ();

   assign if_a.retire_valid = r_valid[0];
   assign if_a.retire_pc    = r_pc;
   assign if_a.retire_instr = r_instr;
   assign if_a.retire_rd    = r_rd;
   assign if_a.retire_we    = r_we;
   assign if_a.retire_wdata = r_wdata;
   assign if_a.arm          = r_arm[0];
   assign if_a.abort        = r_abort[0];
   assign if_a.trig_en      = t_en;
   assign if_a.trig_pc      = t_pc;
   assign if_a.rd_ready     = r_ready[0];

   assign if_b.retire_valid = r_valid[1];
   assign if_b.retire_pc    = r_pc;
   assign if_b.retire_instr = r_instr;
   assign if_b.retire_rd    = r_rd;
   assign if_b.retire_we    = r_we;
   assign if_b.retire_wdata = r_wdata;
   assign if_b.arm          = r_arm[1];
   assign if_b.abort        = r_abort[1];
   assign if_b.trig_en      = t_en;
   assign if_b.trig_pc      = t_pc;
   assign if_b.rd_ready     = r_ready[1];

   retire_trace_buffer #(.DEPTH(DEPTH), .POST_TRIG(8)) u_dut_a (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (if_a)
   );

   retire_trace_buffer #(.DEPTH(DEPTH), .POST_TRIG(0)) u_dut_b (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (if_b)
   );

   int n_vec = 0;
   int n_err = 0;

   // Reference model: 0 idle, 1 armed, 2 post, 3 frozen.
   int           mst   [2] = '{0, 0};
   int           mpost [2] = '{0, 0};
   int           ptrig [2] = '{8, 0};
   trace_entry_t exp_q [2][$];
`ifdef TRACE_TIMESTAMP_EN
   logic [TS_W-1:0] ts_seen [$];
`endif

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic status(input int d, input string tag, input int st, input int cnt,
                         input int wr, input int vld, output trace_entry_t head);
      int   a_st, a_cnt;
      logic a_wr, a_vld;
      @(negedge clk);
      if (d == 0) begin
         a_st = int'(if_a.state); a_cnt = int'(if_a.count);
         a_wr = if_a.wrapped;     a_vld = if_a.rd_valid; head = if_a.rd_entry;
      end else begin
         a_st = int'(if_b.state); a_cnt = int'(if_b.count);
         a_wr = if_b.wrapped;     a_vld = if_b.rd_valid; head = if_b.rd_entry;
      end
      check({tag, "_state"}, 64'(a_st), 64'(st));
      check({tag, "_count"}, 64'(a_cnt), 64'(cnt));
      check({tag, "_rd_valid"}, 64'(a_vld), 64'(vld));
      if (wr >= 0) check({tag, "_wrapped"}, 64'(a_wr), 64'(wr));
      @(posedge clk);
      #1;
   endtask

   function automatic trace_entry_t mk_entry(input logic [31:0] pc, input logic [31:0] wdata);
      trace_entry_t e;
      e       = '0;
      e.pc    = pc;
      e.instr = {pc[15:0], 16'h0093};
      e.rd    = pc[6:2];
      e.we    = pc[2];
      e.wdata = wdata;
      return e;
   endfunction

   task automatic retire(input int d, input logic [31:0] pc, input logic [31:0] wdata);
      trace_entry_t e;
      e          = mk_entry(pc, wdata);
      r_pc       = e.pc;
      r_instr    = e.instr;
      r_rd       = e.rd;
      r_we       = e.we;
      r_wdata    = e.wdata;
      r_valid[d] = 1'b1;
      cycle();
      r_valid[d] = 1'b0;
      if (mst[d] == 1 || mst[d] == 2) begin
         exp_q[d].push_back(e);
         if (exp_q[d].size() > DEPTH) void'(exp_q[d].pop_front());
         if (mst[d] == 1) begin
            if (t_en && pc == t_pc) begin
               if (ptrig[d] == 0) mst[d] = 3;
               else begin
                  mst[d]   = 2;
                  mpost[d] = ptrig[d];
               end
            end
         end else begin
            mpost[d]--;
            if (mpost[d] == 0) mst[d] = 3;
         end
      end
   endtask

   task automatic arm(input int d);
      r_arm[d] = 1'b1;
      cycle();
      r_arm[d] = 1'b0;
      if (mst[d] == 0) begin
         mst[d] = 1;
         exp_q[d].delete();
      end
   endtask

   task automatic drain(input int d, input string tag);
      int           budget;
      trace_entry_t h;
      budget     = 0;
      r_ready[d] = 1'b1;
      while (exp_q[d].size() != 0 && budget < 4 * DEPTH) begin
         cycle();
         budget++;
      end
      r_ready[d] = 1'b0;
      check({tag, "_drain_left"}, 64'(exp_q[d].size()), 64'd0);
      mst[d] = 0;
      status(d, {tag, "_after_drain"}, int'(T_IDLE), 0, -1, 0, h);
   endtask

   // Monitor: every accepted head entry is compared against the scoreboard front.
   initial begin
      logic         v;
      logic         rdy;
      trace_entry_t e;
      trace_entry_t x;
      forever begin
         @(negedge clk);
         for (int d = 0; d < 2; d++) begin
            if (d == 0) begin v = if_a.rd_valid; e = if_a.rd_entry; end
            else        begin v = if_b.rd_valid; e = if_b.rd_entry; end
            rdy = r_ready[d];
            if (v === 1'b1 && rdy === 1'b1) begin
               n_vec++;
               if (exp_q[d].size() == 0) begin
                  n_err++;
                  $display("FAIL pop_unexpected dut%0d: got pc %0h expected no entry", d, e.pc);
               end else begin
                  x = exp_q[d].pop_front();
                  if (e.pc !== x.pc || e.instr !== x.instr || e.rd !== x.rd ||
                      e.we !== x.we || e.wdata !== x.wdata) begin
                     n_err++;
                     $display("FAIL drain_entry dut%0d: got pc %0h instr %0h rd %0d we %0b wdata %0h expected pc %0h instr %0h rd %0d we %0b wdata %0h",
                              d, e.pc, e.instr, e.rd, e.we, e.wdata,
                              x.pc, x.instr, x.rd, x.we, x.wdata);
                  end
`ifdef TRACE_TIMESTAMP_EN
                  ts_seen.push_back(e.ts);
`endif
               end
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      trace_entry_t h;
      for (int d = 0; d < 2; d++) begin
         r_valid[d] = 1'b0; r_arm[d] = 1'b0; r_abort[d] = 1'b0; r_ready[d] = 1'b0;
      end
      rst_n = 1'b0;
      repeat (3) cycle();
      rst_n = 1'b1;

      status(0, "rst_a", int'(T_IDLE), 0, 0, 0, h);
      status(1, "rst_b", int'(T_IDLE), 0, 0, 0, h);

      // Retires without arm are never recorded.
      for (int i = 0; i < 5; i++) retire(0, 32'(i * 4), 32'(i));
      status(0, "noarm", int'(T_IDLE), 0, 0, 0, h);

      // Trigger at PC 12, eight post-trigger entries, with an ignored arm mid-POST.
      t_en = 1'b1;
      t_pc = 32'd12;
      arm(0);
      status(0, "t2_armed", int'(T_ARMED), 0, 0, 0, h);
      for (int i = 0; i <= 10; i++) retire(0, 32'(i * 4), 32'h1000 + 32'(i));
      status(0, "t2_post", int'(T_POST), 11, 0, 0, h);
      arm(0);
      status(0, "t2_arm_ignored", int'(T_POST), 11, 0, 0, h);
      retire(0, 32'd44, 32'h100b);
      status(0, "t2_frozen", int'(T_FROZEN), 12, 0, 1, h);
      check("t2_head_pc", 64'(h.pc), 64'd0);
      retire(0, 32'd48, 32'h100c);
      status(0, "t2_no_capture", int'(T_FROZEN), 12, 0, 1, h);
      drain(0, "t2");

      // Overflow before the trigger: buffer stays full and wrapped.
      t_pc = 32'h1000;
      arm(0);
      for (int i = 0; i < 30; i++) retire(0, 32'h100 + 32'(i * 4), 32'h2000 + 32'(i));
      status(0, "t3_full", int'(T_ARMED), 16, 1, 0, h);
      retire(0, 32'h1000, 32'h5555_aaaa);
      status(0, "t3_post", int'(T_POST), 16, 1, 0, h);
      for (int i = 0; i < 8; i++) retire(0, 32'h2000 + 32'(i * 4), 32'h3000 + 32'(i));
      status(0, "t3_frozen", int'(T_FROZEN), 16, 1, 1, h);
      check("t3_head_pc", 64'(h.pc), 64'h15c);
      drain(0, "t3");

      // POST_TRIG=0: trigger on the first retire freezes immediately.
      t_pc = 32'h80;
      arm(1);
      retire(1, 32'h80, 32'hdead_beef);
      status(1, "t4_frozen", int'(T_FROZEN), 1, 0, 1, h);
      check("t4_wdata", 64'(h.wdata), 64'hdead_beef);
      drain(1, "t4");

      // Abort with arm in the same cycle during POST; then a clean capture.
      t_pc = 32'd8;
      arm(0);
      for (int i = 0; i < 5; i++) retire(0, 32'(i * 4), 32'h4000 + 32'(i));
      status(0, "t5_post", int'(T_POST), 5, 0, 0, h);
      r_abort[0] = 1'b1;
      r_arm[0]   = 1'b1;
      cycle();
      r_abort[0] = 1'b0;
      r_arm[0]   = 1'b0;
      mst[0]     = 0;
      exp_q[0].delete();
      status(0, "t5_aborted", int'(T_IDLE), 0, 0, 0, h);
      t_pc = 32'h400;
      arm(0);
      for (int i = 0; i < 9; i++) retire(0, 32'h400 + 32'(i * 4), 32'h6000 + 32'(i));
      status(0, "t5_frozen", int'(T_FROZEN), 9, 0, 1, h);
      check("t5_head_pc", 64'(h.pc), 64'h400);
      drain(0, "t5");

`ifdef TRACE_TIMESTAMP_EN
      // Two captures four cycles apart.
      ts_seen.delete();
      t_pc = 32'h504;
      arm(1);
      retire(1, 32'h500, 32'h7000);
      repeat (3) cycle();
      retire(1, 32'h504, 32'h7001);
      status(1, "t6_frozen", int'(T_FROZEN), 2, 0, 1, h);
      drain(1, "t6");
      check("t6_ts_count", 64'(ts_seen.size()), 64'd2);
      if (ts_seen.size() == 2)
         check("t6_ts_delta", 64'(TS_W'(ts_seen[1] - ts_seen[0])), 64'd4);
`endif

      repeat (2) cycle();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
